// File: rtl/cu_seq_pkg.sv
// Shared types and constants for the operation sequencer and its arithmetic stage.
package cu_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_AND = 2'b11;

endpackage

// File: rtl/control_unit.sv
// Combinational 4-bit signed arithmetic stage: add, subtract, multiply, bitwise AND.
// Add/sub/and results occupy ResL with ResH cleared; multiply fills {ResH, ResL}.
// Cout is the carry for add and the unsigned borrow for subtract.
module control_unit
   import cu_seq_pkg::*;
(
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Ctrl1,
   input  logic       Ctrl0,
   output logic [3:0] ResH,
   output logic [3:0] ResL,
   output logic       Zero,
   output logic       Overflow,
   output logic       Cout
);

   logic [4:0] sum5;
   logic [7:0] prod;

   // Opcode decode and result/flag generation.
   always_comb begin
      sum5     = '0;
      prod     = '0;
      ResH     = '0;
      ResL     = '0;
      Overflow = 1'b0;
      Cout     = 1'b0;
      case ({Ctrl1, Ctrl0})
         OP_ADD: begin
            sum5     = {1'b0, A} + {1'b0, B};
            ResL     = sum5[3:0];
            Cout     = sum5[4];
            Overflow = (A[3] == B[3]) && (sum5[3] != A[3]);
         end
         OP_SUB: begin
            sum5     = {1'b0, A} - {1'b0, B};
            ResL     = sum5[3:0];
            Cout     = sum5[4];
            Overflow = (A[3] != B[3]) && (sum5[3] != A[3]);
         end
         OP_MUL: begin
            // Low 8 bits of the product of sign-extended operands equal the signed product.
            prod = {{4{A[3]}}, A} * {{4{B[3]}}, B};
            ResH = prod[7:4];
            ResL = prod[3:0];
         end
         default: begin
            ResL = A & B;
         end
      endcase
      Zero = ({ResH, ResL} == 8'h00);
   end

endmodule

// File: rtl/cu_op_sequencer.sv
// Valid/ready operation sequencer wrapped around one control_unit: captures a
// request, evaluates it for one cycle, and presents the registered result.
module cu_op_sequencer
   import cu_seq_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             InValid,
   output logic             InReady,
   input  logic [1:0]       Op,
   input  logic [3:0]       A,
   input  logic [3:0]       B,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [7:0]       Res,
   output logic             Zero,
   output logic             Overflow,
   output logic             Cout,
   output logic             StickyFlag,
   input  logic             ClrSticky,
   output logic [CNT_W-1:0] OpCount
);

   state_t     state;
   logic [1:0] op_q;
   logic [3:0] a_q;
   logic [3:0] b_q;
   logic [3:0] cu_res_h;
   logic [3:0] cu_res_l;
   logic       cu_zero;
   logic       cu_ov;
   logic       cu_cout;
   logic       accept;
   logic       consume;

   // Handshake decode; reset masks both sides so nothing completes during rst.
   always_comb begin
      InReady  = ~rst & ((state == IDLE) | ((state == DONE) & OutReady));
      accept   = InValid & InReady;
      consume  = ~rst & (state == DONE) & OutReady;
      OutValid = (state == DONE);
   end

   control_unit u_cu (
      .A        (a_q),
      .B        (b_q),
      .Ctrl1    (op_q[1]),
      .Ctrl0    (op_q[0]),
      .ResH     (cu_res_h),
      .ResL     (cu_res_l),
      .Zero     (cu_zero),
      .Overflow (cu_ov),
      .Cout     (cu_cout)
   );

   // FSM: IDLE -> EXEC on accept, EXEC -> DONE, DONE -> EXEC/IDLE on consume.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (accept) state <= EXEC;
            EXEC:    state <= DONE;
            DONE:    if (OutReady) state <= InValid ? EXEC : IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Operand registers load only on an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q <= '0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (accept) begin
         op_q <= Op;
         a_q  <= A;
         b_q  <= B;
      end
   end

   // Result and flag registers load in EXEC and hold through backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         Res      <= '0;
         Zero     <= 1'b0;
         Overflow <= 1'b0;
         Cout     <= 1'b0;
      end else if (state == EXEC) begin
         Res      <= {cu_res_h, cu_res_l};
         Zero     <= cu_zero;
         Overflow <= cu_ov;
         Cout     <= cu_cout;
      end
   end

   // Sticky error flag: a flagged capture takes priority over a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         StickyFlag <= 1'b0;
      end else if ((state == EXEC) && (cu_ov || cu_cout)) begin
         StickyFlag <= 1'b1;
      end else if (ClrSticky) begin
         StickyFlag <= 1'b0;
      end
   end

   // Consumed-result counter, free-running wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         OpCount <= '0;
      end else if (consume) begin
         OpCount <= OpCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cu_op_sequencer.sv
// Scoreboard bench for cu_op_sequencer: driver issues directed and random
// traffic, a negedge monitor compares DUT outputs with a behavioural model.
module tb_cu_op_sequencer;
   import cu_seq_pkg::*;

   localparam int CNT_W = 8;
   localparam int CNT_MOD = 1 << CNT_W;

   logic             clk;
   logic             rst;
   logic             InValid;
   logic             InReady;
   logic [1:0]       Op;
   logic [3:0]       A;
   logic [3:0]       B;
   logic             OutValid;
   logic             OutReady;
   logic [7:0]       Res;
   logic             Zero;
   logic             Overflow;
   logic             Cout;
   logic             StickyFlag;
   logic             ClrSticky;
   logic [CNT_W-1:0] OpCount;

   cu_op_sequencer #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .InValid    (InValid),
      .InReady    (InReady),
      .Op         (Op),
      .A          (A),
      .B          (B),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .Res        (Res),
      .Zero       (Zero),
      .Overflow   (Overflow),
      .Cout       (Cout),
      .StickyFlag (StickyFlag),
      .ClrSticky  (ClrSticky),
      .OpCount    (OpCount)
   );

   typedef struct {
      logic [7:0] res;
      logic       zero;
      logic       ov;
      logic       cout;
   } exp_t;

   int   compared = 0;
   int   mismatched = 0;
   exp_t sb_q[$];

   // Model state: what the block holds after the most recent edge.
   bit   m_started = 0;
   bit   m_inflight = 0;
   bit   m_present = 0;
   bit   m_sticky = 0;
   int   m_count = 0;
   int   n_acc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected result straight from the opcode definitions using integer arithmetic.
   function automatic exp_t ref_model(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      exp_t e;
      int ua, ub, sa, sb, s;
      ua = int'(a);
      ub = int'(b);
      sa = a[3] ? ua - 16 : ua;
      sb = b[3] ? ub - 16 : ub;
      e.res = 8'h00; e.zero = 1'b0; e.ov = 1'b0; e.cout = 1'b0;
      case (op)
         OP_ADD: begin
            s = sa + sb;
            e.res = 8'((ua + ub) % 16);
            e.cout = (ua + ub) > 15;
            e.ov = (s > 7) || (s < -8);
         end
         OP_SUB: begin
            s = sa - sb;
            e.res = 8'((ua - ub + 16) % 16);
            e.cout = ua < ub;
            e.ov = (s > 7) || (s < -8);
         end
         OP_MUL: begin
            s = sa * sb;
            e.res = 8'(s);
         end
         default: e.res = 8'(ua & ub);
      endcase
      e.zero = (e.res == 8'h00);
      return e;
   endfunction

   // Monitor: compare outputs against the model, then advance the model over the next edge.
   always @(negedge clk) begin
      bit exp_ready, acc, fire, nxt_present;
      exp_ready = !rst && ((!m_inflight && !m_present) || (m_present && OutReady));
      if (m_started) begin
         chk("InReady", InReady, exp_ready);
         chk("OutValid", OutValid, m_present);
         if (m_present) begin
            if (sb_q.size() == 0) chk("sb_empty", 0, 1);
            else begin
               chk("Res", Res, sb_q[0].res);
               chk("Zero", Zero, sb_q[0].zero);
               chk("Overflow", Overflow, sb_q[0].ov);
               chk("Cout", Cout, sb_q[0].cout);
            end
         end
         chk("OpCount", OpCount, m_count);
         chk("StickyFlag", StickyFlag, m_sticky);
      end
      if (rst) begin
         m_started = 1;
         m_inflight = 0;
         m_present = 0;
         m_sticky = 0;
         m_count = 0;
         sb_q.delete();
      end else if (m_started) begin
         acc = InValid && exp_ready;
         fire = m_present && OutReady;
         if (m_inflight) begin
            nxt_present = 1;
            if (sb_q.size() > 0 && (sb_q[0].ov || sb_q[0].cout)) m_sticky = 1;
            else if (ClrSticky) m_sticky = 0;
         end else begin
            nxt_present = m_present && !OutReady;
            if (ClrSticky) m_sticky = 0;
         end
         if (fire) begin
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            m_count = (m_count + 1) % CNT_MOD;
         end
         if (acc) begin
            sb_q.push_back(ref_model(Op, A, B));
            n_acc++;
         end
         m_inflight = acc;
         m_present = nxt_present;
      end
   end

   task automatic send(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
      bit ok;
      ok = 0;
      Op = op; A = a; B = b; InValid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = InReady;
         @(posedge clk);
         #1;
      end
      InValid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
   endtask

   initial begin
      int start_acc;
      rst = 1'b1; InValid = 1'b0; Op = '0; A = '0; B = '0;
      OutReady = 1'b0; ClrSticky = 1'b0;
      cycles(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_Res", Res, 8'h00);
      chk("rst_Zero", Zero, 0);
      chk("rst_Overflow", Overflow, 0);
      chk("rst_Cout", Cout, 0);
      chk("rst_Sticky", StickyFlag, 0);
      chk("rst_OpCount", OpCount, 0);
      chk("rst_OutValid", OutValid, 0);
      @(posedge clk); #1;

      // Add with immediate consumption.
      OutReady = 1'b1;
      send(OP_ADD, 4'd3, 4'd4);
      cycles(3);
      @(negedge clk);
      chk("add_OpCount", OpCount, 1);
      @(posedge clk); #1;

      // Subtract to zero, then AND.
      send(OP_SUB, 4'd5, 4'd5);
      cycles(3);
      send(OP_AND, 4'hC, 4'hA);
      cycles(3);

      // Signed multiply held under backpressure while new requests are offered.
      OutReady = 1'b0;
      send(OP_MUL, 4'hD, 4'd5);
      InValid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         Op = 2'($urandom); A = 4'($urandom); B = 4'($urandom);
         cycles(1);
      end
      InValid = 1'b0;
      OutReady = 1'b1;
      cycles(3);

      // Carry into sticky, then a second carry capture while clear is held.
      ClrSticky = 1'b1;
      cycles(1);
      ClrSticky = 1'b0;
      send(OP_ADD, 4'hF, 4'd1);
      cycles(3);
      ClrSticky = 1'b1;
      send(OP_ADD, 4'hF, 4'd1);
      cycles(3);
      ClrSticky = 1'b0;
      cycles(2);

      // Back-to-back traffic long enough to wrap the counter.
      do_reset();
      start_acc = n_acc;
      OutReady = 1'b1;
      InValid = 1'b1;
      for (int i = 0; i < 1000 && (n_acc - start_acc) < CNT_MOD + 1; i++) begin
         Op = 2'($urandom); A = 4'($urandom); B = 4'($urandom);
         cycles(1);
      end
      InValid = 1'b0;
      if ((n_acc - start_acc) < CNT_MOD + 1) chk("b2b_timeout", 0, 1);
      cycles(4);
      @(negedge clk);
      chk("wrap_OpCount", OpCount, 1);
      @(posedge clk); #1;

      // Reset while an operation is in EXEC.
      send(OP_ADD, 4'd2, 4'd2);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      cycles(3);
      @(negedge clk);
      chk("rst_exec_OpCount", OpCount, 0);
      @(posedge clk); #1;

      // Random traffic with backpressure, sticky clears and occasional reset.
      for (int i = 0; i < 1500; i++) begin
         InValid   = 1'($urandom_range(0, 1));
         OutReady  = ($urandom_range(0, 3) != 0);
         ClrSticky = ($urandom_range(0, 7) == 0);
         rst       = ($urandom_range(0, 99) == 0);
         Op = 2'($urandom); A = 4'($urandom); B = 4'($urandom);
         cycles(1);
      end
      rst = 1'b0; InValid = 1'b0; OutReady = 1'b1; ClrSticky = 1'b0;
      cycles(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
